tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Receive-side partner of the team's 2:1/N:1 mux path. Takes one serial stream of
//  time-multiplexed samples (slot 0..N_CH-1, slot 0 flagged by frame_sync) and
//  distributes each sample to its own registered channel output.
//  Tracks frame alignment with a HUNT/LOCKED state machine and reports sync errors.
// PARAMETERS
//  N_CH    4   number of channels/slots per frame; legal range >= 2
//  W       8   sample width in bits
//  SLOT_W  2   slot counter width; must equal $clog2(N_CH)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  din         in   W        incoming sample
//  din_valid   in   1        din is a sample this cycle
//  frame_sync  in   1        qualified by din_valid; marks slot 0
//  din_par     in   1        even parity over din (only with TDM_DEMUX_PARITY_EN)
//  ch_data     out  N_CH*W   channel c at bits [c*W +: W]; holds last value
//  ch_update   out  N_CH     1-cycle strobe per channel written
//  frame_done  out  1        1-cycle pulse when slot N_CH-1 is written
//  locked      out  1        1 in LOCKED state
//  sync_err    out  1        1-cycle pulse on alignment error
//  par_err     out  1        1-cycle pulse on parity error (TDM_DEMUX_PARITY_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=HUNT, slot=0, ch_data=0, ch_update=0,
//    frame_done=0, locked=0, sync_err=0, par_err=0. Release is synchronous to clk.
//  - A sample is accepted on a rising edge with din_valid=1; din_valid=0 cycles
//    are ignored and the slot counter holds.
//  - Latency: 1 clock. ch_data[slot] and ch_update[slot] update on the edge that
//    accepts the sample. All strobes are 0 in every other cycle.
//  - HUNT: samples without frame_sync are discarded, no strobes. A sample with
//    frame_sync is written to ch 0, slot -> 1, state -> LOCKED.
//  - LOCKED, accepted sample with slot = s:
//    * s != 0 and frame_sync=0: write ch s; slot = s+1, wrapping N_CH-1 -> 0.
//      s = N_CH-1 also pulses frame_done on the same edge as ch_update[N_CH-1].
//    * s == 0 and frame_sync=1: write ch 0, slot -> 1.
//    * s != 0 and frame_sync=1 (early sync): pulse sync_err; treat sample as
//      slot 0: write ch 0, slot -> 1; stay LOCKED; no frame_done.
//    * s == 0 and frame_sync=0 (missing sync): pulse sync_err; discard sample;
//      state -> HUNT, slot=0.
//  - locked follows the state register (1 in LOCKED).
//  - Slot counter arithmetic is mod N_CH. Non-power-of-2 N_CH wraps explicitly
//    at N_CH-1.
//  - ch_data is never cleared except by reset; HUNT does not clear it.
//  - rst_n asserted mid-frame: immediate return to reset values. The partial frame
//    is lost and the next frame needs frame_sync.
// CONFIGURATION
//  TDM_DEMUX_PARITY_EN defined: din_par and par_err ports exist. An accepted sample
//    with ^{din,din_par}=1 is not written: no ch_update, and par_err pulses. The
//    slot still advances, state is unchanged, and sync checks still apply. A
//    failing sample in HUNT, or one that triggers sync_err, pulses both
//    par_err and sync_err.
//  TDM_DEMUX_PARITY_EN undefined: din_par and par_err ports are absent; every
//    accepted sample is written per the rules above.
// TESTING
//  1. rst_n=0 then release, din_valid=0 for 5 clk -> all outputs 0, locked=0.
//  2. Frame 0x11(sync),0x22,0x33,0x44 back-to-back -> ch_data=0x44_33_22_11,
//     ch_update 0001,0010,0100,1000, frame_done on 4th, locked=1 after 1st.
//  3. 0xAA,0xBB without sync in HUNT -> no strobes, ch_data unchanged, locked=0.
//  4. Locked, sync at slot 2 with din=0x55 -> sync_err=1, ch0=0x55,
//     next sample -> ch1.
//  5. Locked, slot 0 without sync -> sync_err=1, locked=0 next cycle,
//     sample dropped.
//  6. PARITY_EN: slot 1 din=0x01, din_par=0 -> par_err=1, ch1 holds,
//     next sample -> ch2.

Source files
------------

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: spreads a framed serial sample stream onto N_CH registered channels.
// Optional even-parity checking is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
    parameter int N_CH   = 4,
    parameter int W      = 8,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic              din_par,
`endif
    output logic [N_CH*W-1:0] ch_data,
    output logic [N_CH-1:0]   ch_update,
    output logic              frame_done,
    output logic              locked,
    output logic              sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic              par_err
`endif
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    state_t              state, nxt_state;
    logic [SLOT_W-1:0]   slot, nxt_slot, wr_slot;
    logic                wr_en, done_n, serr_n, perr_n, par_bad;

`ifdef TDM_DEMUX_PARITY_EN
    assign par_bad = ^{din, din_par};
`else
    assign par_bad = 1'b0;
`endif

    // A sample with bad parity is never written but still steps the alignment logic.
    always_comb begin
        nxt_state = state;
        nxt_slot  = slot;
        wr_en     = 1'b0;
        wr_slot   = slot;
        done_n    = 1'b0;
        serr_n    = 1'b0;
        perr_n    = 1'b0;
        if (din_valid) begin
            perr_n = par_bad;
            case (state)
                HUNT: begin
                    if (par_bad) begin
                        serr_n = 1'b1;
                    end else if (frame_sync) begin
                        wr_en     = 1'b1;
                        wr_slot   = '0;
                        nxt_slot  = SLOT_ONE;
                        nxt_state = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot == '0) begin
                        if (frame_sync) begin
                            wr_en    = !par_bad;
                            wr_slot  = '0;
                            nxt_slot = SLOT_ONE;
                        end else begin
                            serr_n    = 1'b1;
                            nxt_slot  = '0;
                            nxt_state = HUNT;
                        end
                    end else if (frame_sync) begin
                        serr_n   = 1'b1;
                        wr_en    = !par_bad;
                        wr_slot  = '0;
                        nxt_slot = SLOT_ONE;
                    end else begin
                        wr_en    = !par_bad;
                        done_n   = !par_bad && (slot == LAST_SLOT);
                        nxt_slot = (slot == LAST_SLOT) ? '0 : slot + SLOT_ONE;
                    end
                end
                default: begin
                    nxt_state = HUNT;
                    nxt_slot  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            slot  <= '0;
        end else begin
            state <= nxt_state;
            slot  <= nxt_slot;
        end
    end

    // Channel registers hold their value until overwritten or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data    <= '0;
            ch_update  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (wr_en && (wr_slot == SLOT_W'(c))) begin
                    ch_data[c*W +: W] <= din;
                end
            end
            ch_update  <= wr_en ? (N_CH'(1) << wr_slot) : '0;
            frame_done <= done_n;
            sync_err   <= serr_n;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= perr_n;
        end
    end
`endif

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard testbench for tdm_demux; an independent frame model predicts every output.
// Defining TDM_DEMUX_PARITY_EN also exercises the parity path.
module tb_tdm_demux;

    localparam int N_CH   = 4;
    localparam int W      = 8;
    localparam int SLOT_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [W-1:0]      din;
    logic              din_valid;
    logic              frame_sync;
    logic [N_CH*W-1:0] ch_data;
    logic [N_CH-1:0]   ch_update;
    logic              frame_done;
    logic              locked;
    logic              sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic              din_par;
    logic              par_err;
    bit                par_flip = 1'b0;
`endif

    typedef struct {
        logic [N_CH*W-1:0] data;
        logic [N_CH-1:0]   upd;
        logic              done;
        logic              serr;
        logic              perr;
        logic              lck;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    bit                m_locked;
    int                m_slot;
    logic [N_CH*W-1:0] m_data;

    tdm_demux #(.N_CH(N_CH), .W(W), .SLOT_W(SLOT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
`ifdef TDM_DEMUX_PARITY_EN
        .din_par    (din_par),
        .par_err    (par_err),
`endif
        .ch_data    (ch_data),
        .ch_update  (ch_update),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        m_locked = 1'b0;
        m_slot   = 0;
        m_data   = '0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_data"}, 64'(ch_data), 64'h0);
        checkOutput({tag, "_upd"}, 64'(ch_update), 64'h0);
        checkOutput({tag, "_done"}, 64'(frame_done), 64'h0);
        checkOutput({tag, "_lck"}, 64'(locked), 64'h0);
        checkOutput({tag, "_serr"}, 64'(sync_err), 64'h0);
`ifdef TDM_DEMUX_PARITY_EN
        checkOutput({tag, "_perr"}, 64'(par_err), 64'h0);
`endif
    endtask

    // Drive one cycle, predict its outcome, then compare right after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] d, input logic v, input logic fs);
        exp_t e;
        exp_t got_e;
        bit   bad;
        int   wr;
        @(negedge clk);
        din        = d;
        din_valid  = v;
        frame_sync = fs;
`ifdef TDM_DEMUX_PARITY_EN
        din_par    = (^d) ^ par_flip;
        bad        = par_flip;
`else
        bad        = 1'b0;
`endif
        e.upd  = '0;
        e.done = 1'b0;
        e.serr = 1'b0;
        e.perr = 1'b0;
        wr     = -1;
        if (v) begin
            e.perr = bad;
            if (!m_locked) begin
                if (bad) e.serr = 1'b1;
                else if (fs) begin
                    wr = 0; m_slot = 1; m_locked = 1'b1;
                end
            end else if (m_slot == 0) begin
                if (fs) begin
                    if (!bad) wr = 0;
                    m_slot = 1;
                end else begin
                    e.serr = 1'b1; m_locked = 1'b0;
                end
            end else if (fs) begin
                e.serr = 1'b1;
                if (!bad) wr = 0;
                m_slot = 1;
            end else begin
                if (!bad) begin
                    wr = m_slot;
                    e.done = (m_slot == N_CH - 1);
                end
                m_slot = (m_slot + 1) % N_CH;
            end
        end
        if (wr >= 0) begin
            m_data[wr*W +: W] = d;
            e.upd[wr] = 1'b1;
        end
        e.data = m_data;
        e.lck  = m_locked;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 64'h1, 64'h0);
        end else begin
            got_e = sb.pop_front();
            checkOutput("data", 64'(ch_data), 64'(got_e.data));
            checkOutput("upd", 64'(ch_update), 64'(got_e.upd));
            checkOutput("done", 64'(frame_done), 64'(got_e.done));
            checkOutput("serr", 64'(sync_err), 64'(got_e.serr));
            checkOutput("lck", 64'(locked), 64'(got_e.lck));
`ifdef TDM_DEMUX_PARITY_EN
            checkOutput("perr", 64'(par_err), 64'(got_e.perr));
`endif
        end
    endtask

    initial begin
        din        = '0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        din_par    = 1'b0;
`endif
        rst_n      = 1'b0;
        modelReset();
        #12;
        checkReset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (5) applyStimulus(8'h00, 1'b0, 1'b0);
        checkReset("idle");

        // Unsynchronised samples in HUNT are discarded.
        applyStimulus(8'hAA, 1'b1, 1'b0);
        applyStimulus(8'hBB, 1'b1, 1'b0);
        checkOutput("t3_lck", 64'(locked), 64'h0);

        applyStimulus(8'h11, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b1, 1'b0);
        applyStimulus(8'h33, 1'b1, 1'b0);
        applyStimulus(8'h44, 1'b1, 1'b0);
        checkOutput("t2_data", 64'(ch_data), 64'h44332211);
        checkOutput("t2_done", 64'(frame_done), 64'h1);

        // Early sync at slot 2 restarts the frame.
        applyStimulus(8'h11, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b1);
        checkOutput("t4_serr", 64'(sync_err), 64'h1);
        checkOutput("t4_ch0", 64'(ch_data[7:0]), 64'h55);
        applyStimulus(8'h66, 1'b1, 1'b0);
        checkOutput("t4_ch1", 64'(ch_data[15:8]), 64'h66);
        applyStimulus(8'h77, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h88, 1'b1, 1'b0);

        // Missing sync at slot 0 drops back to HUNT.
        applyStimulus(8'h99, 1'b1, 1'b0);
        checkOutput("t5_lck", 64'(locked), 64'h0);
        checkOutput("t5_data", 64'(ch_data), 64'h88776655);
        applyStimulus(8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic v;
            logic fs;
            v  = ($urandom_range(3) != 0);
            fs = (m_locked && m_slot == 0) ? ($urandom_range(7) != 0) : ($urandom_range(7) == 0);
            applyStimulus(8'($urandom), v, fs);
        end

        // Reset in the middle of a frame returns everything to zero.
        applyStimulus(8'h01, 1'b1, 1'b1);
        applyStimulus(8'h02, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkReset("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h03, 1'b1, 1'b0);
        applyStimulus(8'h04, 1'b1, 1'b1);
        applyStimulus(8'h05, 1'b1, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
        applyStimulus(8'h06, 1'b1, 1'b1);
        par_flip = 1'b1;
        applyStimulus(8'h01, 1'b1, 1'b0);
        checkOutput("t6_perr", 64'(par_err), 64'h1);
        checkOutput("t6_ch1", 64'(ch_data[15:8]), 64'h05);
        par_flip = 1'b0;
        applyStimulus(8'h07, 1'b1, 1'b0);
        checkOutput("t6_ch2", 64'(ch_update), 64'h4);
        par_flip = 1'b1;
        applyStimulus(8'h08, 1'b1, 1'b1);
        applyStimulus(8'h09, 1'b1, 1'b0);
        par_flip = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
